imm_gen: RTL and testbench
==========================

Name: imm_gen

Overview:
- RV32I immediate generator for the pipelined core.
- Decodes the opcode of the current instruction and builds the 32-bit sign-extended immediate for its format (I/S/B/U/J).
- Registers the result so it arrives at the execute stage as o_ImmE, one clock after i_Instr is presented.
- Pure datapath block: no handshake and no stall input.

Parameters:
- None. Data width is fixed at 32 bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i_Instr  input  32  instruction word in the decode stage
- o_ImmE  output  32  registered sign-extended immediate for the execute stage

Behaviour:
- Reset: rst_n low clears o_ImmE to 32'h0000_0000 immediately, without waiting for a clock. This also applies mid-operation. The output stays 0 while rst_n is low.
- Latency: the immediate is computed combinationally from i_Instr[6:0] and captured on each rising clk edge. o_ImmE is therefore valid one cycle after i_Instr. The register updates every cycle; there is no enable.
- Format selection by opcode i_Instr[6:0]:
  - 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR), 1110011 (SYSTEM) -> I-type: {{20{i[31]}}, i[31:20]}
  - 0100011 (STORE) -> S-type: {{20{i[31]}}, i[31:25], i[11:7]}
  - 1100011 (BRANCH) -> B-type: {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}
  - 0110111 (LUI), 0010111 (AUIPC) -> U-type: {i[31:12], 12'b0}
  - 1101111 (JAL) -> J-type: {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}
  - 0110011 (OP, R-type), 0001111 (FENCE), any other/illegal opcode -> 32'h0
- Sign bit is always i_Instr[31]; bit 0 of B/J immediates is always 0.
- funct3/funct7 are ignored, except under the optional feature below.
- Selection logic is fully combinational with a default branch, so no latches are inferred.
- An X/unknown opcode must not lock the register. Normal values resume on the next clock with a valid opcode.

Optional Feature:
- Macro: IMM_GEN_SHAMT_EN.
- Defined: for opcode 0010011 with funct3 = 001 (SLLI) or 101 (SRLI/SRAI), o_ImmE = {27'b0, i[24:20]}, the zero-extended shift amount. The funct7 bits are dropped.
- Not defined: shifts use the normal I-type rule. Example: SRAI x1,x1,3 (32'h4030D093) gives 32'h0000_0403 without the macro and 32'h0000_0003 with it.

Test Plan:
- Reset: hold rst_n=0 with clocks running and i_Instr arbitrary -> o_ImmE=0. Assert rst_n low between edges while output is nonzero -> output drops to 0 with no clock edge.
- I-type, one clock after each input:
  - 32'h00500113 (addi x2,x0,5) -> 32'h00000005
  - 32'hFF718393 (addi x7,x3,-9) -> 32'hFFFFFFF7
  - 32'h06002103 (lw) -> 32'h00000060
- S/B types:
  - 32'h0471AA23 (sw) -> 32'h00000054
  - 32'h02728863 (beq) -> 32'h00000030
  - 32'h00010463 -> 32'h00000008
  - 32'h00210063 -> 32'h00000000
- J/U types:
  - 32'h008001EF (jal x3,+8) -> 32'h00000008
  - 32'h800000EF -> 32'hFFF00000
  - 32'h12345037 (lui) -> 32'h12345000
- R-type and unknown:
  - 32'h0023E233, 32'h004282B3, 32'h402383B3 -> 32'h00000000
  - opcode 7'b1111111 -> 32'h00000000
- Back-to-back: change i_Instr every cycle across all formats -> each o_ImmE matches the previous cycle's instruction with no bubbles. Repeat the SRAI case with and without IMM_GEN_SHAMT_EN.

Source files
------------

// File: rtl/imm_gen.sv
// imm_gen: RV32I immediate generator, registered into the execute stage.
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset, clears o_ImmE
//   i_Instr in  32   instruction word in decode
//   o_ImmE  out 32   sign-extended immediate, valid one cycle after i_Instr
// Optional: define IMM_GEN_SHAMT_EN so SLLI/SRLI/SRAI yield the zero-extended shamt.
module imm_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_Instr,
    output logic [31:0] o_ImmE
);
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;

    logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm, imm;

    assign i_imm = {{20{i_Instr[31]}}, i_Instr[31:20]};
    assign s_imm = {{20{i_Instr[31]}}, i_Instr[31:25], i_Instr[11:7]};
    assign b_imm = {{19{i_Instr[31]}}, i_Instr[31], i_Instr[7], i_Instr[30:25], i_Instr[11:8], 1'b0};
    assign u_imm = {i_Instr[31:12], 12'b0};
    assign j_imm = {{11{i_Instr[31]}}, i_Instr[31], i_Instr[19:12], i_Instr[20], i_Instr[30:21], 1'b0};

    always_comb begin
        imm = '0;
        case (i_Instr[6:0])
`ifdef IMM_GEN_SHAMT_EN
            // funct3 001/101 are the only OP-IMM codes with [13:12] == 01
            OP_IMM:               imm = (i_Instr[13:12] == 2'b01) ? {27'b0, i_Instr[24:20]} : i_imm;
            LOAD, JALR, SYSTEM:   imm = i_imm;
`else
            OP_IMM, LOAD, JALR, SYSTEM: imm = i_imm;
`endif
            STORE:                imm = s_imm;
            BRANCH:               imm = b_imm;
            LUI, AUIPC:           imm = u_imm;
            JAL:                  imm = j_imm;
            default:              imm = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o_ImmE <= '0;
        else        o_ImmE <= imm;
endmodule

// File: tb/tb_imm_gen.sv
// tb_imm_gen: self-checking bench for imm_gen (arithmetic reference model plus literal vectors).
module tb_imm_gen;
    logic        clk = 0;
    logic        rst_n = 0;
    logic [31:0] i_Instr = '0;
    logic [31:0] o_ImmE;
    logic [31:0] exp_q;
    logic        cmp_en = 1;
    int          n_chk = 0;
    int          n_fail = 0;

    imm_gen dut (.clk(clk), .rst_n(rst_n), .i_Instr(i_Instr), .o_ImmE(o_ImmE));

    always #5 clk = ~clk;

    // Reference: rebuild the immediate value from field weights and a signed offset.
    function automatic logic [31:0] model(input logic [31:0] i);
        int v;
        int neg;
        neg = i[31] ? 1 : 0;
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
`ifdef IMM_GEN_SHAMT_EN
                if (i[6:0] == 7'b0010011 && (i[14:12] == 3'd1 || i[14:12] == 3'd5))
                    return 32'(int'(i[24:20]));
`endif
                v = int'(i[31:20]) - neg * 4096;
            end
            7'b0100011: v = int'(i[31:25]) * 32 + int'(i[11:7]) - neg * 4096;
            7'b1100011: v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - neg * 4096;
            7'b0110111, 7'b0010111: return i & 32'hFFFF_F000;
            7'b1101111: v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - neg * (1 << 20);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, req);
        end
    endtask

    // Model pipeline register: what o_ImmE must hold after each edge.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) exp_q <= '0;
        else        exp_q <= model(i_Instr);

    always @(posedge clk) begin
        #3;
        if (cmp_en) check("model", o_ImmE, exp_q);
    end

    task automatic apply(input logic [31:0] instr, input logic [31:0] req, input string name);
        @(negedge clk);
        i_Instr = instr;
        @(posedge clk);
        #1 check(name, o_ImmE, req);
    endtask

    logic [31:0] b2b [12] = '{32'h00500113, 32'h0471AA23, 32'h02728863, 32'h008001EF,
                              32'h12345037, 32'h0023E233, 32'hFF718393, 32'h800000EF,
                              32'h4030D093, 32'h00010463, 32'h12345017, 32'hFFF0C073};

    initial begin
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            i_Instr = $urandom;
            @(posedge clk);
            #1 check("reset_hold", o_ImmE, 32'h0);
        end
        @(negedge clk);
        rst_n = 1;
        apply(32'h00500113, 32'h00000005, "addi_5");
        #1 rst_n = 0;
        #1 check("async_reset", o_ImmE, 32'h0);
        @(negedge clk);
        rst_n = 1;
        apply(32'hFF718393, 32'hFFFFFFF7, "addi_m9");
        apply(32'h06002103, 32'h00000060, "lw");
        apply(32'h0471AA23, 32'h00000054, "sw");
        apply(32'h02728863, 32'h00000030, "beq");
        apply(32'h00010463, 32'h00000008, "br_8");
        apply(32'h00210063, 32'h00000000, "br_0");
        apply(32'h008001EF, 32'h00000008, "jal_8");
        apply(32'h800000EF, 32'hFFF00000, "jal_neg");
        apply(32'h12345037, 32'h12345000, "lui");
        apply(32'h0023E233, 32'h00000000, "r_or");
        apply(32'h004282B3, 32'h00000000, "r_add");
        apply(32'h402383B3, 32'h00000000, "r_sub");
        apply(32'hFFFFFFFF, 32'h00000000, "op_illegal");
        apply(32'h0000000F, 32'h00000000, "fence");
`ifdef IMM_GEN_SHAMT_EN
        apply(32'h4030D093, 32'h00000003, "srai");
`else
        apply(32'h4030D093, 32'h00000403, "srai");
`endif
        @(negedge clk);
        cmp_en = 0;
        i_Instr = 32'hxxxx_xxxx;
        apply(32'hFF718393, 32'hFFFFFFF7, "after_x");
        cmp_en = 1;
        foreach (b2b[k]) begin
            @(negedge clk);
            i_Instr = b2b[k];
        end
        @(negedge clk);
        i_Instr = 32'h0;
        repeat (2) @(posedge clk);
        #4;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
